// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multicycle multiply/divide unit.
package multdiv_pkg;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int WIDTH_DFLT = 32;
  // One shift-add or restoring-subtract step per bit of the operand.
  localparam int ITERS = WIDTH_DFLT;

endpackage

// File: rtl/multdiv_if.sv
// Request/response bundle between the control unit and the mult/div unit.
interface multdiv_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/multdiv_sign_fix.sv
// Converts the unsigned magnitude result of a mult/div into MIPS signed
// results: product negated when operand signs differ, quotient truncated
// toward zero, remainder carries the sign of the dividend.
module multdiv_sign_fix
  import multdiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DFLT
) (
  input  logic               op,
  input  logic               sign_a,
  input  logic               sign_b,
  input  logic [2*WIDTH-1:0] mag,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  logic signed [2*WIDTH-1:0] prod_s;
  logic signed [WIDTH-1:0]   quo_s;
  logic signed [WIDTH-1:0]   rem_s;

  // Apply sign correction; for DIV the upper half holds the remainder.
  always_comb begin
    prod_s = (sign_a ^ sign_b) ? -$signed(mag) : $signed(mag);
    quo_s  = (sign_a ^ sign_b) ? -$signed(mag[WIDTH-1:0]) : $signed(mag[WIDTH-1:0]);
    rem_s  = sign_a ? -$signed(mag[2*WIDTH-1:WIDTH]) : $signed(mag[2*WIDTH-1:WIDTH]);
    hi     = prod_s[2*WIDTH-1:WIDTH];
    lo     = prod_s[WIDTH-1:0];
    if (op == OP_DIV) begin
      hi = rem_s;
      lo = quo_s;
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply/divide unit feeding the Hi/Lo registers.
// Optional build macro MULTDIV_EARLY_TERM_EN: finish after one step when
// a MULT operand is zero or a DIV has |a| < |b| (results unchanged).
module mult_div_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DFLT
) (
  input logic     clk,
  input logic     reset,
  multdiv_if.slave bus
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  op_e                op_q;
  logic               sign_a_q, sign_b_q, dz_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic               accept, first_iter, is_dz, early, finish;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next, div_next, acc_step, fix_mag;
  logic [WIDTH:0]     rem_sh;
  logic               rem_ge;
  logic [WIDTH-1:0]   rem_sub;
  logic [WIDTH-1:0]   hi_fix, lo_fix;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? ((~v) + WIDTH'(1)) : v;
  endfunction

  // One iteration of shift-add multiply and restoring divide on magnitudes.
  // MULT: acc = {partial product, remaining multiplier bits}.
  // DIV:  acc = {partial remainder, dividend bits shifting into quotient}.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    rem_ge   = rem_sh >= {1'b0, opnd_q};
    rem_sub  = rem_sh[WIDTH-1:0] - opnd_q;
    div_next = {(rem_ge ? rem_sub : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], rem_ge};
    acc_step = (op_q == OP_DIV) ? div_next : mul_next;
  end

  // Termination conditions evaluated on the first RUN cycle and at the last count.
  always_comb begin
    accept     = bus.start && (state_q != RUN);
    first_iter = (state_q == RUN) && (cnt_q == '0);
    is_dz      = first_iter && (op_q == OP_DIV) && (opnd_q == '0);
`ifdef MULTDIV_EARLY_TERM_EN
    early = first_iter &&
            (((op_q == OP_MULT) && ((opnd_q == '0) || (acc_q[WIDTH-1:0] == '0))) ||
             ((op_q == OP_DIV) && (opnd_q != '0) && (acc_q[WIDTH-1:0] < opnd_q)));
`else
    early = 1'b0;
`endif
    finish = (state_q == RUN) && ((cnt_q == CNT_LAST) || is_dz || early);
    // Early DIV: quotient 0, remainder is the dividend magnitude; early MULT: 0.
    fix_mag = acc_step;
    if (early) begin
      fix_mag = (op_q == OP_DIV) ? {acc_q[WIDTH-1:0], {WIDTH{1'b0}}} : '0;
    end
  end

  multdiv_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .op     (op_q),
    .sign_a (sign_a_q),
    .sign_b (sign_b_q),
    .mag    (fix_mag),
    .hi     (hi_fix),
    .lo     (lo_fix)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; DONE can chain straight into a new request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (finish) state_d = DONE;
      DONE:    state_d = bus.start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counter, div-by-zero flag and Hi/Lo result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      dz_q  <= 1'b0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else if (accept) begin
      cnt_q <= '0;
      dz_q  <= 1'b0;
    end else if (state_q == RUN) begin
      cnt_q <= cnt_q + CNT_W'(1);
      if (finish) begin
        dz_q <= is_dz;
        if (!is_dz) begin
          hi_q <= hi_fix;
          lo_q <= lo_fix;
        end
      end
    end
  end

  // Operand capture and iteration datapath.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q     <= op_e'(bus.op);
      sign_a_q <= bus.a[WIDTH-1];
      sign_b_q <= bus.b[WIDTH-1];
      opnd_q   <= bus.op ? mag(bus.b) : mag(bus.a);
      acc_q    <= {{WIDTH{1'b0}}, (bus.op ? mag(bus.a) : mag(bus.b))};
    end else if (state_q == RUN) begin
      acc_q <= acc_step;
    end
  end

  assign bus.busy     = (state_q == RUN);
  assign bus.done     = (state_q == DONE);
  assign bus.div_zero = (state_q == DONE) && dz_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit against a plain-arithmetic model.
module tb_mult_div_unit;
  import multdiv_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multdiv_if #(.WIDTH(32)) bus ();

  mult_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = 32'h0;
  logic [31:0] m_lo = 32'h0;

  typedef struct {
    logic        o;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] eh;
    logic [31:0] el;
  } vec_t;

  function automatic longint abs64(input longint v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference: 64-bit signed arithmetic; latency in clock edges after the request edge.
  function automatic void model(input logic o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] eh, output logic [31:0] el,
                                output logic edz, output int lat);
    longint sx, sy, p, q, r;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    edz = 1'b0;
    lat = ITERS;
    if (o == 1'b0) begin
      p  = sx * sy;
      eh = p[63:32];
      el = p[31:0];
`ifdef MULTDIV_EARLY_TERM_EN
      if (x == 0 || y == 0) lat = 1;
`endif
    end else if (y == 0) begin
      eh  = m_hi;
      el  = m_lo;
      edz = 1'b1;
      lat = 1;
    end else begin
      q  = sx / sy;
      r  = sx % sy;
      eh = r[31:0];
      el = q[31:0];
`ifdef MULTDIV_EARLY_TERM_EN
      if (abs64(sx) < abs64(sy)) lat = 1;
`endif
    end
  endfunction

  // Issue one request and follow it to done (bounded); no checking here.
  task automatic run_op(input logic o, input logic [31:0] x, input logic [31:0] y,
                        output int edges, output logic [31:0] rh, output logic [31:0] rl,
                        output logic rdz, output logic busy_bad, output logic seen);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op    = 1'($urandom);
    bus.a     = $urandom;
    bus.b     = $urandom;
    busy_bad  = !bus.busy || bus.done;
    edges     = 0;
    seen      = 1'b0;
    while (!seen && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
      if (bus.done) seen = 1'b1;
      else if (!bus.busy || bus.div_zero) busy_bad = 1'b1;
    end
    rh  = bus.hi;
    rl  = bus.lo;
    rdz = bus.div_zero;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.div_zero} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000", {bus.busy, bus.done, bus.div_zero});
    end
    checks++;
    if ({bus.hi, bus.lo} !== 64'h0) begin
      errors++;
      $display("FAIL reset_hilo: got %h expected 0", {bus.hi, bus.lo});
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_directed();
    vec_t tv[6];
    logic [31:0] eh, el, rh, rl;
    logic edz, rdz, bb, seen;
    int lat, edges;
    tv[0] = '{1'b0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
    tv[1] = '{1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
    tv[2] = '{1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    tv[3] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    tv[4] = '{1'b1, 32'h00000005, 32'h00000002, 32'h00000001, 32'h00000002};
    tv[5] = '{1'b1, 32'h00000005, 32'h00000000, 32'h00000001, 32'h00000002};
    for (int i = 0; i < 6; i++) begin
      model(tv[i].o, tv[i].x, tv[i].y, eh, el, edz, lat);
      run_op(tv[i].o, tv[i].x, tv[i].y, edges, rh, rl, rdz, bb, seen);
      checks++;
      if (!seen || edges != lat) begin
        errors++;
        $display("FAIL dir%0d_latency: got %0d edges (seen=%0b) expected %0d", i, edges, seen, lat);
      end
      checks++;
      if ({rh, rl} !== {tv[i].eh, tv[i].el}) begin
        errors++;
        $display("FAIL dir%0d_result: got hi=%h lo=%h expected hi=%h lo=%h",
                 i, rh, rl, tv[i].eh, tv[i].el);
      end
      checks++;
      if (rdz !== edz || bb) begin
        errors++;
        $display("FAIL dir%0d_flags: got div_zero=%b busy_err=%b expected div_zero=%b busy_err=0",
                 i, rdz, bb, edz);
      end
      m_hi = tv[i].eh;
      m_lo = tv[i].el;
      @(posedge clk);
      #1;
      checks++;
      if ({bus.done, bus.div_zero, bus.busy} !== 3'b000) begin
        errors++;
        $display("FAIL dir%0d_after_done: got done/dz/busy=%b expected 000", i,
                 {bus.done, bus.div_zero, bus.busy});
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] sp[6];
    logic [31:0] x, y, eh, el, rh, rl;
    logic o, edz, rdz, bb, seen;
    int lat, edges;
    sp = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h3};
    for (int i = 0; i < 60; i++) begin
      o = 1'($urandom);
      x = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 5)] : $urandom;
      case ($urandom_range(0, 3))
        0:       y = sp[$urandom_range(0, 5)];
        1:       y = $urandom_range(0, 300) - 150;
        default: y = $urandom;
      endcase
      model(o, x, y, eh, el, edz, lat);
      run_op(o, x, y, edges, rh, rl, rdz, bb, seen);
      checks++;
      if (!seen || edges != lat || rh !== eh || rl !== el || rdz !== edz || bb) begin
        errors++;
        $display("FAIL rand%0d op=%0b a=%h b=%h: got edges=%0d hi=%h lo=%h dz=%b busy_err=%b expected edges=%0d hi=%h lo=%h dz=%b",
                 i, o, x, y, edges, rh, rl, rdz, bb, lat, eh, el, edz);
      end
      m_hi = eh;
      m_lo = el;
    end
  endtask

  task automatic test_ignored_start();
    logic [31:0] eh, el, held_hi, held_lo;
    logic edz, seen, held_bad;
    int lat, edges;
    model(1'b0, 32'd12345, 32'hFFFFFD5A, eh, el, edz, lat);
    held_hi = bus.hi;
    held_lo = bus.lo;
    held_bad = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 1'b0;
    bus.a     = 32'd12345;
    bus.b     = 32'hFFFFFD5A;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 100) begin
      if (edges == 5) begin
        bus.start = 1'b1;
        bus.op    = 1'b1;
        bus.a     = 32'h00000064;
        bus.b     = 32'h00000007;
      end
      if (edges == 8) bus.start = 1'b0;
      @(posedge clk);
      #1;
      edges++;
      if (bus.done) seen = 1'b1;
      else if (bus.hi !== held_hi || bus.lo !== held_lo) held_bad = 1'b1;
    end
    checks++;
    if (!seen || edges != lat) begin
      errors++;
      $display("FAIL ignored_start_latency: got %0d edges (seen=%0b) expected %0d", edges, seen, lat);
    end
    checks++;
    if ({bus.hi, bus.lo} !== {eh, el}) begin
      errors++;
      $display("FAIL ignored_start_result: got hi=%h lo=%h expected hi=%h lo=%h", bus.hi, bus.lo, eh, el);
    end
    checks++;
    if (held_bad) begin
      errors++;
      $display("FAIL ignored_start_hold: got hi/lo changed before done expected held %h/%h", held_hi, held_lo);
    end
    m_hi = eh;
    m_lo = el;
  endtask

  task automatic test_back_to_back();
    logic [31:0] eh, el, eh2, el2, rh, rl;
    logic edz, rdz, bb, seen;
    int lat, lat2, edges;
    model(1'b0, 32'h00001234, 32'h00005678, eh, el, edz, lat);
    run_op(1'b0, 32'h00001234, 32'h00005678, edges, rh, rl, rdz, bb, seen);
    checks++;
    if (!seen || {rh, rl} !== {eh, el}) begin
      errors++;
      $display("FAIL b2b_first: got hi=%h lo=%h seen=%0b expected hi=%h lo=%h", rh, rl, seen, eh, el);
    end
    m_hi = eh;
    m_lo = el;
    model(1'b1, 32'hFFFFFC18, 32'h00000007, eh2, el2, edz, lat2);
    bus.start = 1'b1;
    bus.op    = 1'b1;
    bus.a     = 32'hFFFFFC18;
    bus.b     = 32'h00000007;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    checks++;
    if ({bus.busy, bus.done} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_accept: got busy/done=%b expected 10", {bus.busy, bus.done});
    end
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
      if (bus.done) seen = 1'b1;
    end
    checks++;
    if (!seen || edges != lat2) begin
      errors++;
      $display("FAIL b2b_latency: got %0d edges (seen=%0b) expected %0d", edges, seen, lat2);
    end
    checks++;
    if ({bus.hi, bus.lo} !== {eh2, el2}) begin
      errors++;
      $display("FAIL b2b_second: got hi=%h lo=%h expected hi=%h lo=%h", bus.hi, bus.lo, eh2, el2);
    end
    m_hi = eh2;
    m_lo = el2;
  endtask

  task automatic test_reset_abort();
    logic saw_done;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 1'b0;
    bus.a     = 32'h0BADBEEF;
    bus.b     = 32'h00C0FFEE;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.div_zero, bus.hi, bus.lo} !== 67'h0) begin
      errors++;
      $display("FAIL reset_abort_state: got busy=%b done=%b hi=%h lo=%h expected all 0",
               bus.busy, bus.done, bus.hi, bus.lo);
    end
    @(negedge clk);
    reset = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL reset_abort_quiet: got done/busy activity after reset expected none");
    end
    m_hi = 32'h0;
    m_lo = 32'h0;
  endtask

  task automatic test_early();
    logic [31:0] eh, el, rh, rl;
    logic edz, rdz, bb, seen;
    int lat, edges;
    model(1'b0, 32'h0, 32'h9, eh, el, edz, lat);
    run_op(1'b0, 32'h0, 32'h9, edges, rh, rl, rdz, bb, seen);
    checks++;
    if (!seen || edges != lat || {rh, rl} !== 64'h0 || bb) begin
      errors++;
      $display("FAIL early_mult_zero: got edges=%0d hi=%h lo=%h busy_err=%b expected edges=%0d hi=0 lo=0",
               edges, rh, rl, bb, lat);
    end
    model(1'b1, 32'h3, 32'hFFFFFFF6, eh, el, edz, lat);
    run_op(1'b1, 32'h3, 32'hFFFFFFF6, edges, rh, rl, rdz, bb, seen);
    checks++;
    if (!seen || edges != lat || rh !== 32'h3 || rl !== 32'h0 || rdz !== 1'b0) begin
      errors++;
      $display("FAIL early_div_small: got edges=%0d hi=%h lo=%h dz=%b expected edges=%0d hi=00000003 lo=00000000 dz=0",
               edges, rh, rl, rdz, lat);
    end
    m_hi = eh;
    m_lo = el;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got simulation timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignored_start();
    test_back_to_back();
    test_reset_abort();
    test_early();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
